ram_be_init: RTL and testbench
==============================

// Module: ram_be_init
// PURPOSE
//  Parametrised single-port synchronous RAM for the factorial datapath. Successor to the
//  fixed 256x64 ram: configurable width/depth, per-byte write enables and a registered
//  read with valid strobe. Also has a built-in clear engine that fills the array with
//  INIT_VALUE after reset or on request, so every factorial run starts from known storage.
// PARAMETERS
//  DATA_WIDTH  64                  word width in bits; multiple of 8
//  ADDR_WIDTH  8                   address width
//  DEPTH       2**ADDR_WIDTH       implemented words; 2 <= DEPTH <= 2**ADDR_WIDTH
//  INIT_VALUE  {DATA_WIDTH{1'b0}}  word written by the clear engine
// PORTS
//  clk       in   1             rising-edge clock
//  reset     in   1             asynchronous, active-high reset
//  cen       in   1             access enable, active high (ignored while busy)
//  wen       in   1             1 = write, 0 = read (qualified by cen)
//  s_addr    in   ADDR_WIDTH    word address
//  s_din     in   DATA_WIDTH    write data
//  s_be      in   DATA_WIDTH/8  byte enables; bit i covers s_din[8i+7:8i]
//  clr       in   1             request full-array clear (one-cycle pulse, sampled in IDLE)
//  s_dout    out  DATA_WIDTH    read data, registered
//  rd_valid  out  1             one-cycle strobe: s_dout updated this cycle
//  busy      out  1             clear engine active; user accesses dropped
//  err       out  1             one-cycle strobe: access to s_addr >= DEPTH
// BEHAVIOUR
//  - Reset (async assert): s_dout=0, rd_valid=0, err=0, busy=1, state=CLEAR, clr_ptr=0.
//    Array contents are not reset directly; the clear engine fills them.
//  - FSM, two states:
//    CLEAR: each edge writes INIT_VALUE to mem[clr_ptr], clr_ptr++. Edge that writes
//           DEPTH-1 -> IDLE, busy=0 from that edge. Clear takes exactly DEPTH cycles.
//           clr, cen ignored; rd_valid=0; s_dout holds.
//    IDLE:  clr=1 -> CLEAR, clr_ptr=0, busy=1 next edge. An access in the same cycle is
//           dropped (clr wins). No rd_valid, no err.
//  - Write (IDLE, cen=1, wen=1, addr<DEPTH): mem[addr] byte i <= s_din byte i where
//    s_be[i]=1; other bytes keep old value. s_be=0 is a legal no-op. s_dout, rd_valid
//    unchanged/0.
//  - Read (IDLE, cen=1, wen=0, addr<DEPTH): s_dout <= mem[addr] at next edge, rd_valid=1
//    for that cycle. Latency 1. Back-to-back reads give one word per cycle. s_dout holds
//    its last value when no read is taking place.
//  - Read immediately after a write to the same address returns the new data.
//  - addr >= DEPTH (only when DEPTH < 2**ADDR_WIDTH): write dropped. Read gives
//    s_dout=0, rd_valid=1. err=1 for one cycle in both cases.
//  - cen=0: no array change, rd_valid=0, err=0; s_dout holds.
//  - Reset asserted mid-clear or mid-access restarts the clear from address 0. A partial
//    write in the reset cycle need not land; it is overwritten by the clear anyway.
// TESTING
//  1 reset, idle inputs -> busy=1 for exactly DEPTH cycles then 0; read addr 0..DEPTH-1
//    all return INIT_VALUE with rd_valid pulse each.
//  2 write 64'hAA @2, 64'hAB @3 (s_be=8'hFF); read 3,2 -> s_dout 64'hAB then 64'hAA,
//    1-cycle latency each.
//  3 @2=64'h1122334455667788; write 64'hFFFFFFFFFFFFFFFF s_be=8'h0F -> read
//    64'h11223344FFFFFFFF.
//  4 DEPTH=200, ADDR_WIDTH=8: write @250 then read @250 -> err pulse both, s_dout=0,
//    rd_valid=1; @249 (aliased? no) earlier data untouched.
//  5 in IDLE assert clr with cen=1,wen=1 @5 -> write dropped, busy DEPTH cycles, @5
//    reads INIT_VALUE.
//  6 assert reset at clear cycle 10, release -> busy restarts, lasts full DEPTH cycles;
//    cen pulses during busy give no rd_valid/err.

Source files
------------

// File: rtl/ram_be_init.sv
// Single-port synchronous RAM with per-byte write enables, a registered read port with
// a valid strobe, and a clear engine that fills the array with INIT_VALUE.
module ram_be_init #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DEPTH      = 2**ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cen,
    input  logic                    wen,
    input  logic [ADDR_WIDTH-1:0]   s_addr,
    input  logic [DATA_WIDTH-1:0]   s_din,
    input  logic [DATA_WIDTH/8-1:0] s_be,
    input  logic                    clr,
    output logic [DATA_WIDTH-1:0]   s_dout,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if ((DATA_WIDTH % 8) != 0 || DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_params
        $error("ram_be_init: illegal DATA_WIDTH/DEPTH/ADDR_WIDTH combination");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [0:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q,  clr_ptr_d;
    logic [DATA_WIDTH-1:0] s_dout_q,   s_dout_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  err_q,      err_d;

    logic                  in_range;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_be;

    assign in_range = ({1'b0, s_addr} < DEPTH_EXT);

    // The clear engine and the user port share the single write port of the array.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        s_dout_d   = s_dout_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = s_addr;
        wr_data    = s_din;
        wr_be      = s_be;

        case (state_q)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_ptr_q;
                wr_data = INIT_VALUE;
                wr_be   = '1;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                if (clr) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end else if (cen) begin
                    err_d = !in_range;
                    if (wen) begin
                        wr_en = in_range;
                    end else begin
                        rd_valid_d = 1'b1;
                        s_dout_d   = in_range ? mem_q[s_addr] : '0;
                    end
                end
            end
        endcase
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            s_dout_q   <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            s_dout_q   <= s_dout_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the array has no reset; the clear engine initialises it after every reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign s_dout   = s_dout_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;
    assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_be_init.sv
// Bench for ram_be_init (DEPTH=200 of 256): directed cases plus random traffic checked
// against an array-based reference model.
module tb_ram_be_init;

    localparam int          DW   = 64;
    localparam int          AW   = 8;
    localparam int          DEP  = 200;
    localparam logic [63:0] INIT = 64'h5A5A_0000_C3C3_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic          cen, wen, clr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_din;
    logic [7:0]    s_be;
    logic [DW-1:0] s_dout;
    logic          rd_valid, busy, err;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] ref_mem [DEP];
    int          ref_busy;
    logic [63:0] ref_dout;

    ram_be_init #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEP),
        .INIT_VALUE(INIT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cen     (cen),
        .wen     (wen),
        .s_addr  (s_addr),
        .s_din   (s_din),
        .s_be    (s_be),
        .clr     (clr),
        .s_dout  (s_dout),
        .rd_valid(rd_valid),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict its effect, then check outputs after the edge.
    task automatic cycle(input logic c, input logic w, input logic [7:0] a,
                         input logic [63:0] d, input logic [7:0] be, input logic cl);
        logic exp_valid;
        logic exp_err;
        cen = c; wen = w; s_addr = a; s_din = d; s_be = be; clr = cl;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (ref_busy > 0) begin
            ref_busy--;
            if (ref_busy == 0) begin
                for (int i = 0; i < DEP; i++) ref_mem[i] = INIT;
            end
        end else if (cl) begin
            ref_busy = DEP;
        end else if (c) begin
            if (int'(a) >= DEP) begin
                exp_err = 1'b1;
                if (!w) begin
                    exp_valid = 1'b1;
                    ref_dout  = '0;
                end
            end else if (w) begin
                for (int i = 0; i < 8; i++) begin
                    if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                exp_valid = 1'b1;
                ref_dout  = ref_mem[a];
            end
        end
        @(posedge clk);
        #1;
        check("rd_valid", 64'(rd_valid), 64'(exp_valid));
        check("err", 64'(err), 64'(exp_err));
        check("s_dout", s_dout, ref_dout);
        check("busy", 64'(busy), 64'(ref_busy != 0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_dout", s_dout, 64'h0);
        check("rst_valid", 64'(rd_valid), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_busy", 64'(busy), 64'h1);
        ref_dout = '0;
        ref_busy = DEP;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_hold", 64'(busy), 64'h1);
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h0, 64'h0, 8'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; cen = 1'b0; wen = 1'b0; clr = 1'b0;
        s_addr = '0; s_din = '0; s_be = '0;
        ref_busy = DEP;
        ref_dout = '0;
        #2;

        // Clear after reset lasts exactly DEP cycles; every word reads back INIT.
        do_reset();
        idle(DEP);
        for (int a = 0; a < DEP; a++) cycle(1'b1, 1'b0, 8'(a), 64'h0, 8'h0, 1'b0);
        check("t1_last", s_dout, INIT);

        // Full-word writes then reads in reverse order.
        cycle(1'b1, 1'b1, 8'd2, 64'hAA, 8'hFF, 1'b0);
        cycle(1'b1, 1'b1, 8'd3, 64'hAB, 8'hFF, 1'b0);
        cycle(1'b1, 1'b0, 8'd3, 64'h0, 8'h0, 1'b0);
        check("t2_rd3", s_dout, 64'hAB);
        cycle(1'b1, 1'b0, 8'd2, 64'h0, 8'h0, 1'b0);
        check("t2_rd2", s_dout, 64'hAA);

        // Partial byte-enable merge and read-after-write.
        cycle(1'b1, 1'b1, 8'd2, 64'h1122334455667788, 8'hFF, 1'b0);
        cycle(1'b1, 1'b1, 8'd2, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b0);
        cycle(1'b1, 1'b1, 8'd2, 64'h0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'd2, 64'h0, 8'h0, 1'b0);
        check("t3_merge", s_dout, 64'h11223344FFFFFFFF);

        // Out-of-range accesses flag err and never alias onto real words.
        cycle(1'b1, 1'b1, 8'd199, 64'hCAFE, 8'hFF, 1'b0);
        cycle(1'b1, 1'b1, 8'd250, 64'hDEAD, 8'hFF, 1'b0);
        check("t4_wr_err", 64'(err), 64'h1);
        cycle(1'b1, 1'b0, 8'd250, 64'h0, 8'h0, 1'b0);
        check("t4_rd_err", 64'(err), 64'h1);
        check("t4_rd_zero", s_dout, 64'h0);
        cycle(1'b1, 1'b0, 8'd199, 64'h0, 8'h0, 1'b0);
        check("t4_rd199", s_dout, 64'hCAFE);

        // clr wins over a simultaneous write.
        cycle(1'b1, 1'b1, 8'd5, 64'h1234, 8'hFF, 1'b1);
        idle(DEP);
        cycle(1'b1, 1'b0, 8'd5, 64'h0, 8'h0, 1'b0);
        check("t5_rd5", s_dout, INIT);

        // Reset ten cycles into a clear restarts it; accesses while busy are ignored.
        cycle(1'b0, 1'b0, 8'd0, 64'h0, 8'h0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, i[0], 8'(i), 64'h77, 8'hFF, 1'b0);
        do_reset();
        for (int i = 0; i < DEP; i++) cycle(1'(i % 3 == 0), 1'b0, 8'(i), 64'h0, 8'h0, 1'b0);
        check("t6_idle", 64'(busy), 64'h0);

        // Random traffic with occasional clears and out-of-range addresses.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), {$urandom, $urandom}, 8'($urandom),
                  1'($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
